avr_xmem_mailbox: RTL and testbench

//  Responder on the AVR core's external data-memory (SRAM) bus: decodes sram_cs/oe/we, drives

---
 rtl/avr_xmem_mailbox.sv | 230 +++++++++++++++++++++++
 tb/tb_avr_xmem_mailbox.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/avr_xmem_mailbox.sv
// Byte mailbox on the AVR external data-memory bus: RX FIFO (host->AVR), TX FIFO (AVR->host),
// status/count/control registers, blocking DATA accesses with timeout, and a level IRQ.

module avr_xmem_mailbox_fifo #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
endmodule

module avr_xmem_mailbox #(
    parameter int ADDR_W     = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] sram_a,
    input  logic [7:0]        sram_d_out,
    output logic [7:0]        sram_d_in,
    input  logic              sram_cs,
    input  logic              sram_oe,
    input  logic              sram_we,
    output logic              sram_wait,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 2);

    localparam logic [ADDR_W-1:0] A_DATA   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_RXCNT  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_TXCNT  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(4);

    typedef enum logic [1:0] {IDLE, RD_BLOCK, RD_DONE, WR_BLOCK} state_t;

    state_t        state, state_n;
    logic [TW-1:0] to_cnt;
    logic          cnt_clr, expired;
    logic [7:0]    rd_data, rd_val, reg_rdata;
    logic          rd_load, reg_wr;
    logic          irq_en, rx_to, tx_to, set_rx_to, set_tx_to;
    logic          flush_cycle;

    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]    rx_head;
    logic [CW-1:0] rx_count, tx_count;

    // Requests are ignored while reset is held so the bus sees no stall.
    logic req, is_wr, is_data;
    assign req     = ~rst & sram_cs & (sram_oe | sram_we);
    assign is_wr   = sram_we;
    assign is_data = (sram_a == A_DATA);
    assign expired = (TIMEOUT != 0) && (to_cnt == TW'(TIMEOUT - 1));

    assign flush_cycle = reg_wr & (sram_a == A_CTRL) & sram_d_out[1];
    assign rx_ready    = ~rx_full & ~flush_cycle;
    assign rx_push     = rx_valid & rx_ready;
    assign tx_valid    = ~tx_empty;
    assign tx_pop      = tx_valid & tx_ready & ~flush_cycle;
    assign irq         = irq_en & ~rx_empty;
    assign sram_d_in   = rd_data;

    avr_xmem_mailbox_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_rx (
        .clk(clk), .rst(rst), .flush(flush_cycle),
        .push(rx_push), .din(rx_data), .pop(rx_pop),
        .head(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
    );

    avr_xmem_mailbox_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_tx (
        .clk(clk), .rst(rst), .flush(flush_cycle),
        .push(tx_push), .din(sram_d_out), .pop(tx_pop),
        .head(tx_data), .count(tx_count), .full(tx_full), .empty(tx_empty)
    );

    always_comb begin
        reg_rdata = 8'h00;
        case (sram_a)
            A_DATA:   reg_rdata = rx_head;
            A_STATUS: reg_rdata = {4'b0, tx_to, rx_to, tx_full, ~rx_empty};
            A_RXCNT:  reg_rdata = 8'(rx_count);
            A_TXCNT:  reg_rdata = 8'(tx_count);
            A_CTRL:   reg_rdata = {7'b0, irq_en};
            default:  reg_rdata = 8'h00;
        endcase
    end

    always_comb begin
        state_n   = state;
        sram_wait = 1'b0;
        cnt_clr   = 1'b0;
        rd_load   = 1'b0;
        rd_val    = 8'h00;
        rx_pop    = 1'b0;
        tx_push   = 1'b0;
        reg_wr    = 1'b0;
        set_rx_to = 1'b0;
        set_tx_to = 1'b0;
        case (state)
            IDLE: begin
                if (req && is_wr) begin
                    if (is_data && tx_full) begin
                        sram_wait = 1'b1;
                        cnt_clr   = 1'b1;
                        state_n   = WR_BLOCK;
                    end else if (is_data) begin
                        tx_push = 1'b1;
                    end else begin
                        reg_wr = 1'b1;
                    end
                end else if (req) begin
                    sram_wait = 1'b1;
                    if (is_data && rx_empty) begin
                        cnt_clr = 1'b1;
                        state_n = RD_BLOCK;
                    end else begin
                        rd_load = 1'b1;
                        rd_val  = reg_rdata;
                        rx_pop  = is_data;
                        state_n = RD_DONE;
                    end
                end
            end
            RD_BLOCK: begin
                sram_wait = 1'b1;
                if (!rx_empty) begin
                    rx_pop  = 1'b1;
                    rd_load = 1'b1;
                    rd_val  = rx_head;
                    state_n = RD_DONE;
                end else if (expired) begin
                    rd_load   = 1'b1;
                    rd_val    = 8'hFF;
                    set_rx_to = 1'b1;
                    state_n   = RD_DONE;
                end
            end
            RD_DONE: state_n = IDLE;
            WR_BLOCK: begin
                if (!tx_full) begin
                    tx_push = 1'b1;
                    state_n = IDLE;
                end else if (expired) begin
                    set_tx_to = 1'b1;
                    state_n   = IDLE;
                end else begin
                    sram_wait = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            to_cnt  <= '0;
            rd_data <= 8'h00;
            irq_en  <= 1'b0;
            rx_to   <= 1'b0;
            tx_to   <= 1'b0;
        end else begin
            state <= state_n;
            if (cnt_clr)
                to_cnt <= '0;
            else if (state == RD_BLOCK || state == WR_BLOCK)
                to_cnt <= to_cnt + 1'b1;
            if (rd_load)
                rd_data <= rd_val;
            if (reg_wr && sram_a == A_CTRL)
                irq_en <= sram_d_out[0];
            // Sticky flags: a timeout in the same cycle as a clear keeps the flag set.
            if (set_rx_to)
                rx_to <= 1'b1;
            else if (reg_wr && sram_a == A_STATUS && sram_d_out[2])
                rx_to <= 1'b0;
            if (set_tx_to)
                tx_to <= 1'b1;
            else if (reg_wr && sram_a == A_STATUS && sram_d_out[3])
                tx_to <= 1'b0;
        end
    end
endmodule

// File: tb/tb_avr_xmem_mailbox.sv
// Directed bench for avr_xmem_mailbox: register vector table plus blocking/timeout/flush/reset sequences.

module tb_avr_xmem_mailbox;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sram_a;
    logic [7:0] sram_d_out, sram_d_in;
    logic       sram_cs, sram_oe, sram_we, sram_wait;
    logic [7:0] rx_data, tx_data;
    logic       rx_valid, rx_ready, tx_valid, tx_ready, irq;

    int checks = 0;
    int failures = 0;

    avr_xmem_mailbox #(.ADDR_W(3), .FIFO_DEPTH(16), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .sram_a(sram_a), .sram_d_out(sram_d_out), .sram_d_in(sram_d_in),
        .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we), .sram_wait(sram_wait),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef enum logic [1:0] {OP_RD, OP_WR, OP_HPUSH, OP_HPOP} op_t;
    typedef struct packed {
        op_t        op;
        logic [2:0] a;
        logic [7:0] d;
        logic [7:0] exp;
        logic [7:0] ew;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // All bus/host tasks start and end 1 time unit after a rising edge.
    task automatic bus_read(input logic [2:0] a, output logic [7:0] d, output int waits);
        bit done = 0;
        sram_a = a; sram_cs = 1; sram_oe = 1; sram_we = 0;
        waits = 0; d = 8'hxx;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (!sram_wait) begin d = sram_d_in; done = 1; end
            else waits++;
            @(posedge clk); #1;
        end
        sram_cs = 0; sram_oe = 0;
        if (!done) chk("bus_read_bound", 0, 1);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d, output int waits);
        bit done = 0;
        sram_a = a; sram_d_out = d; sram_cs = 1; sram_oe = 0; sram_we = 1;
        waits = 0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (!sram_wait) done = 1;
            else waits++;
            @(posedge clk); #1;
        end
        sram_cs = 0; sram_we = 0;
        if (!done) chk("bus_write_bound", 0, 1);
    endtask

    task automatic host_push(input logic [7:0] d);
        rx_valid = 1; rx_data = d;
        @(negedge clk);
        chk("host_push_ready", rx_ready, 1);
        @(posedge clk); #1;
        rx_valid = 0;
    endtask

    task automatic host_pop(input logic [7:0] exp);
        tx_ready = 1;
        @(negedge clk);
        chk("host_pop_valid", tx_valid, 1);
        chk("host_pop_data", tx_data, exp);
        @(posedge clk); #1;
        tx_ready = 0;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [7:0] exp, input int ew);
        logic [7:0] d;
        int w;
        bus_read(a, d, w);
        chk({name, "_data"}, d, exp);
        chk({name, "_wait"}, w, ew);
    endtask

    task automatic wr_chk(input string name, input logic [2:0] a, input logic [7:0] d, input int ew);
        int w;
        bus_write(a, d, w);
        chk({name, "_wait"}, w, ew);
    endtask

    initial begin
        int w;
        logic [7:0] d;

        rst = 1; sram_a = 0; sram_d_out = 0; sram_cs = 0; sram_oe = 0; sram_we = 0;
        rx_data = 0; rx_valid = 0; tx_ready = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_d_in", sram_d_in, 0);
        chk("rst_wait", sram_wait, 0);
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_irq", irq, 0);
        @(posedge clk); #1;
        rst = 0;

        vecs = '{
            '{OP_HPUSH, 3'd0, 8'h11, 8'h00, 8'd0},
            '{OP_HPUSH, 3'd0, 8'h22, 8'h00, 8'd0},
            '{OP_RD,    3'd2, 8'h00, 8'h02, 8'd1},
            '{OP_RD,    3'd1, 8'h00, 8'h01, 8'd1},
            '{OP_RD,    3'd0, 8'h00, 8'h11, 8'd1},
            '{OP_RD,    3'd0, 8'h00, 8'h22, 8'd1},
            '{OP_RD,    3'd2, 8'h00, 8'h00, 8'd1},
            '{OP_RD,    3'd1, 8'h00, 8'h00, 8'd1},
            '{OP_WR,    3'd4, 8'h01, 8'h00, 8'd0},
            '{OP_RD,    3'd4, 8'h00, 8'h01, 8'd1},
            '{OP_WR,    3'd5, 8'hAA, 8'h00, 8'd0},
            '{OP_RD,    3'd5, 8'h00, 8'h00, 8'd1},
            '{OP_RD,    3'd7, 8'h00, 8'h00, 8'd1},
            '{OP_WR,    3'd0, 8'hA1, 8'h00, 8'd0},
            '{OP_WR,    3'd0, 8'hB2, 8'h00, 8'd0},
            '{OP_RD,    3'd3, 8'h00, 8'h02, 8'd1},
            '{OP_HPOP,  3'd0, 8'h00, 8'hA1, 8'd0},
            '{OP_HPOP,  3'd0, 8'h00, 8'hB2, 8'd0},
            '{OP_RD,    3'd3, 8'h00, 8'h00, 8'd1},
            '{OP_WR,    3'd4, 8'h00, 8'h00, 8'd0},
            '{OP_RD,    3'd4, 8'h00, 8'h00, 8'd1}
        };

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_RD:    rd_chk($sformatf("vec%0d_rd", i), vecs[i].a, vecs[i].exp, int'(vecs[i].ew));
                OP_WR:    wr_chk($sformatf("vec%0d_wr", i), vecs[i].a, vecs[i].d, int'(vecs[i].ew));
                OP_HPUSH: host_push(vecs[i].d);
                OP_HPOP:  host_pop(vecs[i].exp);
                default:  ;
            endcase
        end

        // Blocking read: host byte arrives while the AVR is stalled.
        fork
            bus_read(3'd0, d, w);
            begin
                repeat (9) @(posedge clk);
                #1 rx_valid = 1; rx_data = 8'h5A;
                @(posedge clk); #1 rx_valid = 0;
            end
        join
        chk("blk_rd_data", d, 8'h5A);
        chk("blk_rd_wait", w, 11);

        // Read timeout on empty RX.
        rd_chk("to_rd", 3'd0, 8'hFF, 1 + TMO);
        rd_chk("to_status", 3'd1, 8'h04, 1);
        wr_chk("to_clr", 3'd1, 8'h04, 0);
        rd_chk("to_status_clr", 3'd1, 8'h00, 1);

        // Fill TX, then a blocked write released by one host pop.
        for (int i = 0; i < 16; i++)
            wr_chk($sformatf("fill%0d", i), 3'd0, 8'(8'h30 + i), 0);
        rd_chk("full_txcnt", 3'd3, 8'd16, 1);
        rd_chk("full_status", 3'd1, 8'h02, 1);
        fork
            bus_write(3'd0, 8'h99, w);
            begin
                repeat (3) @(posedge clk);
                #1 tx_ready = 1;
                @(negedge clk);
                chk("blk_wr_head", tx_data, 8'h30);
                @(posedge clk); #1 tx_ready = 0;
            end
        join
        chk("blk_wr_wait", w, 4);
        rd_chk("blk_wr_txcnt", 3'd3, 8'd16, 1);

        // Write timeout with TX full: byte dropped, tx_to set.
        wr_chk("wto", 3'd0, 8'hCC, TMO);
        rd_chk("wto_status", 3'd1, 8'h0A, 1);
        wr_chk("wto_clr", 3'd1, 8'h08, 0);
        rd_chk("wto_status_clr", 3'd1, 8'h02, 1);
        for (int i = 1; i < 16; i++)
            host_pop(8'(8'h30 + i));
        host_pop(8'h99);
        rd_chk("drain_txcnt", 3'd3, 8'd0, 1);

        // IRQ and flush.
        wr_chk("irq_en", 3'd4, 8'h01, 0);
        rx_valid = 1; rx_data = 8'h77;
        @(negedge clk);
        chk("irq_before", irq, 0);
        @(posedge clk); #1 rx_valid = 0;
        @(negedge clk);
        chk("irq_after", irq, 1);
        @(posedge clk); #1;
        host_push(8'h78);
        wr_chk("tx_one", 3'd0, 8'h55, 0);
        fork
            bus_write(3'd4, 8'h03, w);
            begin
                rx_valid = 1; rx_data = 8'hEE;
                @(negedge clk);
                chk("flush_rx_ready", rx_ready, 0);
                @(posedge clk); #1 rx_valid = 0;
            end
        join
        chk("flush_wait", w, 0);
        @(negedge clk);
        chk("flush_irq", irq, 0);
        chk("flush_tx_valid", tx_valid, 0);
        chk("flush_rx_ready_after", rx_ready, 1);
        @(posedge clk); #1;
        rd_chk("flush_rxcnt", 3'd2, 8'd0, 1);
        rd_chk("flush_txcnt", 3'd3, 8'd0, 1);
        rd_chk("flush_ctrl", 3'd4, 8'h01, 1);

        // Reset in the middle of a blocked read.
        wr_chk("pre_rst_tx", 3'd0, 8'h05, 0);
        sram_a = 3'd0; sram_cs = 1; sram_oe = 1; sram_we = 0;
        @(negedge clk);
        chk("mid_wait_idle", sram_wait, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_wait_block", sram_wait, 1);
        @(posedge clk); #1;
        rst = 1; sram_cs = 0; sram_oe = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("post_rst_wait", sram_wait, 0);
        chk("post_rst_tx_valid", tx_valid, 0);
        chk("post_rst_rx_ready", rx_ready, 1);
        chk("post_rst_irq", irq, 0);
        @(posedge clk); #1;
        rd_chk("post_rst_rxcnt", 3'd2, 8'd0, 1);
        rd_chk("post_rst_txcnt", 3'd3, 8'd0, 1);
        rd_chk("post_rst_ctrl", 3'd4, 8'h00, 1);
        rd_chk("post_rst_status", 3'd1, 8'h00, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
